debug_step_ctrl: RTL and testbench
==================================

// Module: debug_step_ctrl
// PURPOSE
//  Parametrised successor to the board-level single-step path (button sync + key filter -> processor clock).
//  Debounces step/run pushbuttons and generates a one-cycle CPU clock-enable pulse.
//  Modes: single step, free run at a programmable rate, burst of N steps, run to a PC breakpoint.
//  Sits between the raw board keys and the Processor's clock/enable input. Status outputs feed the debug hex mux.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles required before a debounced level changes (>=1)
//  RATE_W           26      width of RateDiv
//  STEP_W           8       width of StepCount/StepsDone
//  PC_W             7       width of PC/BrkPC
// PORTS
//  Clk        in   1       system clock (CLOCK_50)
//  Reset      in   1       asynchronous, active-high reset
//  StepBtn    in   1       raw async pushbutton, active high (top level inverts KEY)
//  RunBtn     in   1       raw async pushbutton, active high; toggles run/halt
//  Mode       in   2       00 single, 01 free run, 10 burst, 11 run-to-breakpoint
//  RateDiv    in   RATE_W  Clk cycles between pulses in run; 0 is treated as 1
//  StepCount  in   STEP_W  burst length (mode 10)
//  PC         in   PC_W    current processor PC
//  BrkPC      in   PC_W    breakpoint address (mode 11)
//  CpuEn      out  1       one-cycle enable pulse to processor
//  Running    out  1       1 in RUN state
//  StepsDone  out  STEP_W  pulses issued since last run entry
//  BrkHit     out  1       sticky: run halted on breakpoint
// BEHAVIOUR
//  - Reset: state HALT, CpuEn=0, Running=0, StepsDone=0, BrkHit=0, synchronisers/debounced levels=0, counters=0.
//  - Per button: 2-flop synchroniser, then debounce counter. Debounced level flips when the synced input has
//    differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
//  - Press pulse = registered rising edge of debounced level. Raw rise sampled at edge t, held stable ->
//    press pulse high for exactly cycle t+DEBOUNCE_CYCLES+3. Releases produce no pulse.
//  - HALT: step press -> CpuEn=1 next cycle, BrkHit cleared, StepsDone unchanged.
//    Run press with Mode!=00 -> RUN. Mode latched, StepsDone=0, BrkHit=0, rate counter=0. Run press in Mode 00 is ignored.
//    Step and run presses in the same cycle: run wins, step dropped.
//  - RUN: rate counter increments each cycle; at count==max(RateDiv,1)-1 it wraps to 0 (tick).
//    First tick is RateDiv cycles after entry. Tick -> CpuEn pulse, StepsDone+1 (saturating at all-ones).
//  - Mode 10: StepCount==0 -> return to HALT on the first tick without a pulse. Otherwise HALT in the cycle
//    after the pulse that makes StepsDone==StepCount.
//  - Mode 11: at each tick except the first of the run, if PC==BrkPC -> no pulse, BrkHit=1, HALT.
//    The first tick always pulses, so a run can leave the breakpoint address.
//  - Run press in RUN -> HALT. If it coincides with a tick, halt wins and no pulse is issued. Step presses in RUN are ignored.
//  - Mode/StepCount changes during RUN have no effect; latched at entry. RateDiv is live.
//  - CpuEn is never high on two consecutive cycles (RateDiv 0/1 gives every other cycle: tick then idle).
//  - Reset mid-run: immediate HALT, all outputs cleared, any pending pulse is lost.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. StepBtn bouncing 1,0,1 per cycle, then held 10 cycles -> exactly one CpuEn pulse, 7 cycles after the last rise.
//  2. Mode=01, RateDiv=5, run press -> CpuEn at 5,10,15,... cycles after entry. Second run press -> Running=0, no further pulses.
//  3. Mode=10, StepCount=3, RateDiv=2 -> exactly 3 pulses, StepsDone=3, Running=0. StepCount=0 -> zero pulses, HALT.
//  4. Mode=11, BrkPC=7, PC increments after each pulse from 5, also run started at PC=7 -> first pulse issued;
//     halt at PC==7 with BrkHit=1.
//  5. Run press coinciding with tick -> no CpuEn, HALT. Step+run press same cycle in HALT -> RUN, no step pulse.
//  6. Reset asserted asynchronously mid-burst -> all outputs 0 immediately. No CpuEn after release until a new press.

Source files
------------

// File: rtl/debug_step_ctrl.sv
// Debounced step/run keys driving a one-cycle CPU clock-enable pulse, with
// single-step, free-run, burst and run-to-breakpoint modes.
module debug_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RATE_W          = 26,
  parameter int STEP_W          = 8,
  parameter int PC_W            = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_btn_i,
  input  logic              run_btn_i,
  input  logic [1:0]        mode_i,
  input  logic [RATE_W-1:0] rate_div_i,
  input  logic [STEP_W-1:0] step_count_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [PC_W-1:0]   brk_pc_i,
  output logic              cpu_en_o,
  output logic              running_o,
  output logic [STEP_W-1:0] steps_done_o,
  output logic              brk_hit_o
);

  localparam int                DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [RATE_W-1:0] RATE_ZERO = {RATE_W{1'b0}};
  localparam logic [RATE_W-1:0] RATE_ONE  = RATE_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b10;
  localparam logic [1:0] MODE_BRK    = 2'b11;

  logic [1:0] raw_s;
  logic [1:0] press_s;

  assign raw_s = {run_btn_i, step_btn_i};

  // Index 0 is the step key, index 1 the run key.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_dly_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        press_q     <= 1'b0;
        db_cnt_q    <= DB_ZERO;
      end else begin
        sync1_q     <= raw_s[b];
        sync2_q     <= sync1_q;
        level_dly_q <= level_q;
        press_q     <= level_q & ~level_dly_q;
        if (sync2_q == level_q) begin
          db_cnt_q <= DB_ZERO;
        end else if (db_cnt_q == DB_LAST) begin
          level_q  <= sync2_q;
          db_cnt_q <= DB_ZERO;
        end else begin
          db_cnt_q <= db_cnt_q + DB_ONE;
        end
      end
    end

    assign press_s[b] = press_q;
  end

  typedef enum logic [0:0] {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] steps_q;
  logic [RATE_W-1:0] rate_cnt_q;
  logic              first_q;
  logic              cpu_en_q;
  logic              running_q;
  logic              brk_hit_q;

  logic [RATE_W-1:0] rate_last_s;
  logic              wrap_s;
  logic              tick_s;
  logic              step_s;
  logic              run_s;

  assign step_s = press_s[0];
  assign run_s  = press_s[1];

  // >= rather than == so a live RateDiv reduction cannot strand the counter
  // above the new limit; the extra qualifier keeps CpuEn off on back-to-back cycles.
  always_comb begin
    rate_last_s = RATE_ZERO;
    if (rate_div_i != RATE_ZERO) begin
      rate_last_s = rate_div_i - RATE_ONE;
    end else begin
      rate_last_s = RATE_ZERO;
    end
    wrap_s = (rate_cnt_q >= rate_last_s);
    tick_s = wrap_s & ~cpu_en_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_HALT;
      mode_q     <= MODE_SINGLE;
      count_q    <= STEP_ZERO;
      steps_q    <= STEP_ZERO;
      rate_cnt_q <= RATE_ZERO;
      first_q    <= 1'b0;
      cpu_en_q   <= 1'b0;
      running_q  <= 1'b0;
      brk_hit_q  <= 1'b0;
    end else begin
      cpu_en_q <= 1'b0;
      case (state_q)
        S_HALT: begin
          if (run_s && (mode_i != MODE_SINGLE)) begin
            state_q    <= S_RUN;
            running_q  <= 1'b1;
            mode_q     <= mode_i;
            count_q    <= step_count_i;
            steps_q    <= STEP_ZERO;
            brk_hit_q  <= 1'b0;
            rate_cnt_q <= RATE_ZERO;
            first_q    <= 1'b1;
          end else if (step_s && !run_s) begin
            cpu_en_q  <= 1'b1;
            brk_hit_q <= 1'b0;
          end
        end
        S_RUN: begin
          rate_cnt_q <= wrap_s ? RATE_ZERO : (rate_cnt_q + RATE_ONE);
          if (run_s) begin
            state_q   <= S_HALT;
            running_q <= 1'b0;
          end else if ((mode_q == MODE_BURST) && (count_q != STEP_ZERO) && (steps_q == count_q)) begin
            state_q   <= S_HALT;
            running_q <= 1'b0;
          end else if (tick_s) begin
            if ((mode_q == MODE_BURST) && (count_q == STEP_ZERO)) begin
              state_q   <= S_HALT;
              running_q <= 1'b0;
            end else if ((mode_q == MODE_BRK) && !first_q && (pc_i == brk_pc_i)) begin
              state_q   <= S_HALT;
              running_q <= 1'b0;
              brk_hit_q <= 1'b1;
            end else begin
              cpu_en_q <= 1'b1;
              first_q  <= 1'b0;
              if (steps_q != STEP_MAX) begin
                steps_q <= steps_q + STEP_ONE;
              end
            end
          end
        end
        default: begin
          state_q   <= S_HALT;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en_o     = cpu_en_q;
  assign running_o    = running_q;
  assign steps_done_o = steps_q;
  assign brk_hit_o    = brk_hit_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl with DEBOUNCE_CYCLES=4: a key sampled high
// at edge t is acted on by the control FSM at edge t+7.
module tb_debug_step_ctrl;

  localparam int DB     = 4;
  localparam int RATE_W = 26;
  localparam int STEP_W = 8;
  localparam int PC_W   = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              step_btn = 1'b0;
  logic              run_btn = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [RATE_W-1:0] rate = '0;
  logic [STEP_W-1:0] scount = '0;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_base = '0;
  logic [PC_W-1:0]   brk = '0;
  logic              cpu_en;
  logic              running;
  logic [STEP_W-1:0] steps;
  logic              brk_hit;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int pc_mark = 0;
  int mark = 0;

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RATE_W(RATE_W),
    .STEP_W(STEP_W),
    .PC_W(PC_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .step_btn_i(step_btn),
    .run_btn_i(run_btn),
    .mode_i(mode),
    .rate_div_i(rate),
    .step_count_i(scount),
    .pc_i(pc),
    .brk_pc_i(brk),
    .cpu_en_o(cpu_en),
    .running_o(running),
    .steps_done_o(steps),
    .brk_hit_o(brk_hit)
  );

  always #5 clk = ~clk;

  // Processor model: every enable pulse advances the PC mid-cycle.
  always @(negedge clk) if (cpu_en === 1'b1) pulses = pulses + 1;
  assign pc = pc_base + PC_W'(pulses - pc_mark);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns just after the edge where the FSM acts on the press.
  task automatic press(input logic s, input logic r);
    step_btn = s;
    run_btn  = r;
    ticks(7);
    step_btn = 1'b0;
    run_btn  = 1'b0;
    tick();
  endtask

  initial begin
    ticks(3);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_steps", 32'(steps), 32'd0);
    chk("rst_brk", 32'(brk_hit), 32'd0);
    rst = 1'b0;
    ticks(3);

    // 1: bouncing step key, single pulse 7 cycles after last rise
    mark = pulses;
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1;
    ticks(7);
    chk("t1_no_early", 32'(cpu_en), 32'd0);
    tick();
    chk("t1_pulse", 32'(cpu_en), 32'd1);
    tick();
    chk("t1_pulse_end", 32'(cpu_en), 32'd0);
    tick();
    step_btn = 1'b0;
    ticks(12);
    chk("t1_one_pulse", 32'(pulses - mark), 32'd1);
    chk("t1_running", 32'(running), 32'd0);
    chk("t1_steps", 32'(steps), 32'd0);

    // 2: free run at rate 5, halted by a second run press
    mode = 2'b01; rate = 26'd5;
    mark = pulses;
    press(1'b0, 1'b1);
    chk("t2_running", 32'(running), 32'd1);
    ticks(4);
    chk("t2_no_early", 32'(cpu_en), 32'd0);
    tick();
    chk("t2_pulse5", 32'(cpu_en), 32'd1);
    chk("t2_steps1", 32'(steps), 32'd1);
    ticks(5);
    chk("t2_pulse10", 32'(cpu_en), 32'd1);
    chk("t2_steps2", 32'(steps), 32'd2);
    tick();
    chk("t2_gap", 32'(cpu_en), 32'd0);
    press(1'b0, 1'b1);
    chk("t2_halted", 32'(running), 32'd0);
    ticks(10);
    chk("t2_pulses", 32'(pulses - mark), 32'd3);
    chk("t2_steps3", 32'(steps), 32'd3);

    // 3: burst of 3 at rate 2, then burst of 0
    mode = 2'b10; scount = 8'd3; rate = 26'd2;
    mark = pulses;
    press(1'b0, 1'b1);
    chk("t3_running", 32'(running), 32'd1);
    ticks(2);
    chk("t3_p1", 32'(cpu_en), 32'd1);
    ticks(2);
    chk("t3_p2_steps", 32'(steps), 32'd2);
    ticks(2);
    chk("t3_p3", 32'(cpu_en), 32'd1);
    chk("t3_p3_steps", 32'(steps), 32'd3);
    tick();
    chk("t3_halt", 32'(running), 32'd0);
    ticks(6);
    chk("t3_pulses", 32'(pulses - mark), 32'd3);
    chk("t3_steps_final", 32'(steps), 32'd3);
    scount = 8'd0;
    mark = pulses;
    press(1'b0, 1'b1);
    chk("t3z_running", 32'(running), 32'd1);
    chk("t3z_steps", 32'(steps), 32'd0);
    tick();
    chk("t3z_still_run", 32'(running), 32'd1);
    tick();
    chk("t3z_halt", 32'(running), 32'd0);
    chk("t3z_no_pulse", 32'(cpu_en), 32'd0);
    ticks(4);
    chk("t3z_pulses", 32'(pulses - mark), 32'd0);

    // 4: run to breakpoint 7 from PC 5, then restart from PC 7
    mode = 2'b11; rate = 26'd3; brk = 7'd7;
    pc_base = 7'd5; pc_mark = pulses;
    ticks(4);
    press(1'b0, 1'b1);
    chk("t4_running", 32'(running), 32'd1);
    ticks(3);
    chk("t4_p1", 32'(cpu_en), 32'd1);
    ticks(3);
    chk("t4_p2", 32'(cpu_en), 32'd1);
    ticks(3);
    chk("t4_halt", 32'(running), 32'd0);
    chk("t4_brk_hit", 32'(brk_hit), 32'd1);
    chk("t4_no_pulse", 32'(cpu_en), 32'd0);
    chk("t4_steps", 32'(steps), 32'd2);
    chk("t4_pc", 32'(pc), 32'd7);
    ticks(6);
    press(1'b0, 1'b1);
    chk("t4b_running", 32'(running), 32'd1);
    chk("t4b_brk_clr", 32'(brk_hit), 32'd0);
    ticks(3);
    chk("t4b_first_pulse", 32'(cpu_en), 32'd1);
    ticks(2);
    press(1'b0, 1'b1);
    chk("t4b_halt", 32'(running), 32'd0);
    chk("t4b_steps", 32'(steps), 32'd4);
    chk("t4b_brk", 32'(brk_hit), 32'd0);
    chk("t4b_pc", 32'(pc), 32'd11);

    // 5a: halt press coinciding with a tick suppresses the pulse
    mode = 2'b01; rate = 26'd5;
    ticks(6);
    press(1'b0, 1'b1);
    ticks(7);
    press(1'b0, 1'b1);
    chk("t5_halt", 32'(running), 32'd0);
    chk("t5_no_pulse", 32'(cpu_en), 32'd0);
    chk("t5_steps", 32'(steps), 32'd2);

    // 5b: step+run together enters RUN with no step pulse; rate 0 pulses every other cycle
    rate = 26'd0;
    ticks(6);
    press(1'b1, 1'b1);
    chk("t5b_running", 32'(running), 32'd1);
    chk("t5b_no_step", 32'(cpu_en), 32'd0);
    tick();
    chk("t5b_r0_p1", 32'(cpu_en), 32'd1);
    tick();
    chk("t5b_r0_gap", 32'(cpu_en), 32'd0);
    tick();
    chk("t5b_r0_p2", 32'(cpu_en), 32'd1);
    chk("t5b_steps", 32'(steps), 32'd2);

    // 6: async reset in the middle of a burst
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    ticks(3);
    mode = 2'b10; scount = 8'd5; rate = 26'd2;
    press(1'b0, 1'b1);
    ticks(4);
    chk("t6_pre_pulse", 32'(cpu_en), 32'd1);
    chk("t6_pre_steps", 32'(steps), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("t6_rst_running", 32'(running), 32'd0);
    chk("t6_rst_steps", 32'(steps), 32'd0);
    chk("t6_rst_brk", 32'(brk_hit), 32'd0);
    #2 rst = 1'b0;
    mark = pulses;
    ticks(20);
    chk("t6_no_pulse", 32'(pulses - mark), 32'd0);
    chk("t6_halted", 32'(running), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
